// File: rtl/neuron_pkg.sv
// Shared types for the neuron fan-out path: word width, lane count, lane select
// and the per-lane slot state encoding.
package neuron_pkg;
    localparam int WORD_W    = 32;
    localparam int NUM_LANES = 4;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [1:0]        lane_sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;
endpackage

// File: rtl/demux_slot.sv
// One output lane: a 1-entry valid/ready holding register plus a saturating
// count of words handed to the consumer. Slot state is exported for debug.
module demux_slot
    import neuron_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output slot_state_t       o_state,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    slot_state_t       r_state;
    slot_state_t       w_next_state;
    logic              w_drain;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;

    assign w_drain = (r_state == SLOT_FULL) && i_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            SLOT_EMPTY: if (i_load) w_next_state = SLOT_FULL;
            // A drain with a same-edge refill keeps the slot full.
            SLOT_FULL:  if (w_drain && !i_load) w_next_state = SLOT_EMPTY;
            default:    w_next_state = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_load) begin
                r_data <= i_data;
            end
            if (w_drain && (r_count != CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_state = r_state;
    assign o_data  = r_data;
    assign o_count = r_count;
endmodule

// File: rtl/demux_32by1_4.sv
// Registered 1-to-4 word distributor: each input word goes to the lane named by
// in_sel; only the selected lane can stall the input.
module demux_32by1_4
    import neuron_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int CNT_W  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  lane_sel_t                             in_sel,
    input  logic [DATA_W-1:0]                     in_data,
    output logic [NUM_LANES-1:0]                  out_valid,
    input  logic [NUM_LANES-1:0]                  out_ready,
    output logic [NUM_LANES-1:0][DATA_W-1:0]      out_data,
    output logic [NUM_LANES-1:0][CNT_W-1:0]       out_count
);
    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and a held word stays put until taken.
    slot_state_t          w_state [NUM_LANES];
    logic [NUM_LANES-1:0] w_load;

    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign w_load[g] = in_valid && in_ready && (in_sel == lane_sel_t'(g));

        demux_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[g]),
            .i_data  (in_data),
            .i_ready (out_ready[g]),
            .o_state (w_state[g]),
            .o_data  (out_data[g]),
            .o_count (out_count[g])
        );

        assign out_valid[g] = (w_state[g] == SLOT_FULL);
    end
endmodule
